wb_fifo_pipelined: RTL and testbench
====================================

Name: wb_fifo_pipelined

Overview:
Parametrised Wishbone store-and-forward FIFO bridge, successor to the single-outstanding byte FIFO.
- Upstream side: a write-only Wishbone B4 pipelined device that pushes words into the buffer.
- Downstream side: a pipelined Wishbone controller that forwards each word as a write.
- New capabilities: configurable data width, up to MAX_OUTSTANDING in-flight downstream transactions, downstream error capture, flush, and level/almost-full status.
- Sits between a bus master (e.g. UART/DMA producer) and a slower peripheral.

Parameters:
DATA_WIDTH, 8, word width of the buffer and of both data buses.
ADDR_WIDTH, 4, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH.
MAX_OUTSTANDING, 2, maximum issued-but-unacknowledged downstream transactions; legal range 1..DEPTH.
AF_THRESH, DEPTH-2, level at or above which almost_full_o is asserted; legal range 1..DEPTH.

Ports:
clk_i  in  1  single clock for both bus sides.
rst_ni  in  1  asynchronous, active-low reset.
s_cyc_i  in  1  upstream cycle.
s_stb_i  in  1  upstream strobe.
s_we_i  in  1  upstream write enable.
s_dat_i  in  DATA_WIDTH  upstream write data.
s_ack_o  out  1  upstream write acknowledge.
s_err_o  out  1  upstream error, returned for read requests.
s_stall_o  out  1  upstream stall.
m_cyc_o  out  1  downstream cycle.
m_stb_o  out  1  downstream strobe.
m_we_o  out  1  downstream write enable; tied to 1.
m_dat_o  out  DATA_WIDTH  downstream write data.
m_ack_i  in  1  downstream acknowledge.
m_err_i  in  1  downstream error.
m_stall_i  in  1  downstream stall.
flush_i  in  1  discard all queued, not-yet-issued words.
level_o  out  ADDR_WIDTH+1  occupied entries: queued plus in-flight.
almost_full_o  out  1  asserted when level_o >= AF_THRESH.
err_o  out  1  sticky downstream-error flag.

Behaviour:
- Reset:
  - rst_ni low clears all pointers and counters and err_o, asynchronously.
  - Every output except m_we_o and m_dat_o is 0 while in reset. m_we_o is 1; m_dat_o is don't-care.
  - Buffer storage is not reset.
  - Reset mid-transaction drops m_cyc_o immediately and abandons in-flight transactions. Any ack arriving after release is ignored.
- Pointers:
  - wr_ptr, iss_ptr, ret_ptr, each ADDR_WIDTH bits, wrap modulo DEPTH.
  - level (ADDR_WIDTH+1 bits) = queued + outstanding.
  - outstanding counter is clog2(MAX_OUTSTANDING+1) bits.
- Upstream:
  - req = s_cyc_i & s_stb_i.
  - s_stall_o = req & s_we_i & (full | flush_i), where full = (level == DEPTH).
  - push = req & s_we_i & !s_stall_o. On push, write buffer[wr_ptr] and increment wr_ptr.
  - s_ack_o is registered and goes high exactly 1 cycle after each push.
  - A read request (req & !s_we_i) never stalls, never pushes, and yields s_err_o high 1 cycle later.
  - Full is judged on the registered level: a retire in the same cycle does not un-stall a push.
- Downstream:
  - m_stb_o = (queued > 0) & (outstanding < MAX_OUTSTANDING).
  - m_dat_o = buffer[iss_ptr].
  - m_cyc_o = m_stb_o | (outstanding > 0).
  - All downstream outputs are derived from registers only; there is no combinational path from any input.
  - Issue on m_stb_o & !m_stall_i: increment iss_ptr and outstanding. While stalled, m_dat_o is held stable.
  - Retire on (m_ack_i | m_err_i) & (outstanding > 0): increment ret_ptr, decrement outstanding and level.
  - ack/err received while outstanding == 0 is ignored.
  - m_err_i retires the entry (no retry) and sets err_o.
  - Issue and retire in the same cycle leave outstanding unchanged.
- Level:
  - push only: +1. Retire only: -1. Push and retire together: unchanged.
  - level never exceeds DEPTH and never underflows.
- Flush (flush_i high for one cycle):
  - wr_ptr <= iss_ptr; level <= outstanding, less 1 if a retire occurs in the same cycle.
  - Clears err_o unless m_err_i is retiring in the same cycle.
  - Blocks push that cycle via stall.
  - In-flight transactions complete normally.
  - Issue is suppressed in the flush cycle.
- almost_full_o is decoded from the level register.

Test Plan:
- Reset, then push 0xA5 with downstream ack at latency 1 -> s_ack_o at cycle+1; m_stb_o at cycle+1 with m_dat_o=0xA5; level_o sequence 0,1,0.
- DEPTH=16, m_stall_i held high, 17 pushes -> pushes 1-16 acked; 17th stalled with s_stall_o=1; level_o=16, almost_full_o=1 from level 14; release stall -> 17th accepted after first retire.
- MAX_OUTSTANDING=2, ack latency 3, 4 queued words -> two back-to-back strobes, then m_stb_o low until the first ack; m_cyc_o continuous until the 4th ack; words delivered in order.
- m_err_i on 2nd of 3 words -> all 3 retired; err_o=1 and sticky; level_o reaches 0; a later flush_i pulse clears err_o.
- 5 queued, 1 in flight, flush_i pulse -> level_o=1; queued words never issued; in-flight word retires on its ack; a push in the flush cycle is stalled.
- Upstream read request -> s_err_o=1 one cycle later; no s_ack_o; level_o unchanged.
- Assert rst_ni low mid-burst -> m_cyc_o, m_stb_o, s_ack_o drop immediately; level_o=0 after release.

Source files
------------

// File: rtl/wb_fifo_pipelined_if.sv
// Bus bundle for the FIFO bridge: upstream write-only Wishbone device side
// plus downstream pipelined Wishbone controller side.
interface wb_fifo_pipelined_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_cyc_i;
    logic                  s_stb_i;
    logic                  s_we_i;
    logic [DATA_WIDTH-1:0] s_dat_i;
    logic                  s_ack_o;
    logic                  s_err_o;
    logic                  s_stall_o;

    logic                  m_cyc_o;
    logic                  m_stb_o;
    logic                  m_we_o;
    logic [DATA_WIDTH-1:0] m_dat_o;
    logic                  m_ack_i;
    logic                  m_err_i;
    logic                  m_stall_i;

    // Bridge view
    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_dat_i, m_ack_i, m_err_i, m_stall_i,
        output s_ack_o, s_err_o, s_stall_o, m_cyc_o, m_stb_o, m_we_o, m_dat_o
    );

    // Environment view: upstream producer plus downstream peripheral
    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_dat_i, m_ack_i, m_err_i, m_stall_i,
        input  s_ack_o, s_err_o, s_stall_o, m_cyc_o, m_stb_o, m_we_o, m_dat_o
    );
endinterface

// File: rtl/wb_fifo_pipelined.sv
// Store-and-forward Wishbone FIFO bridge: pushes from an upstream pipelined
// device, forwards each word as a downstream write with bounded in-flight count.
module wb_fifo_pipelined #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int AF_THRESH       = (2**ADDR_WIDTH) - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    wb_fifo_pipelined_if.slave    bus,
    input  logic                  flush_i,
    output logic [ADDR_WIDTH:0]   level_o,
    output logic                  almost_full_o,
    output logic                  err_o
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [OW-1:0] MAXO_L  = OW'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] iss_ptr_q, iss_ptr_d;
    logic [ADDR_WIDTH-1:0] ret_ptr_q, ret_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic                  err_q, err_d;
    logic                  s_ack_q, s_ack_d;
    logic                  s_err_q, s_err_d;

    logic          req, full, stall, push, m_stb, issue, retire;
    logic [LW-1:0] queued;

    always_comb begin
        req    = bus.s_cyc_i & bus.s_stb_i;
        full   = (level_q == DEPTH_L);
        // Full is judged on the registered level, so a same-cycle retire never un-stalls
        stall  = req & bus.s_we_i & (full | flush_i);
        push   = req & bus.s_we_i & ~stall;
        queued = level_q - LW'(outst_q);
        m_stb  = (queued != '0) & (outst_q < MAXO_L);
        issue  = m_stb & ~bus.m_stall_i & ~flush_i;
        retire = (bus.m_ack_i | bus.m_err_i) & (outst_q != '0);
    end

    always_comb begin
        wr_ptr_d  = flush_i ? iss_ptr_q : wr_ptr_q + ADDR_WIDTH'(push);
        iss_ptr_d = iss_ptr_q + ADDR_WIDTH'(issue);
        ret_ptr_d = ret_ptr_q + ADDR_WIDTH'(retire);
        outst_d   = outst_q + OW'(issue) - OW'(retire);
        // Flush keeps only what is already on the downstream bus
        level_d   = flush_i ? LW'(outst_q) - LW'(retire)
                            : level_q + LW'(push) - LW'(retire);
        err_d     = err_q;
        if (retire && bus.m_err_i) err_d = 1'b1;
        else if (flush_i)          err_d = 1'b0;
        s_ack_d   = push;
        s_err_d   = req & ~bus.s_we_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            iss_ptr_q <= '0;
            ret_ptr_q <= '0;
            level_q   <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            s_ack_q   <= 1'b0;
            s_err_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            iss_ptr_q <= iss_ptr_d;
            ret_ptr_q <= ret_ptr_d;
            level_q   <= level_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            s_ack_q   <= s_ack_d;
            s_err_q   <= s_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.s_dat_i;
    end

    // The issue/retire pointer distance must always track the in-flight count
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (ADDR_WIDTH'(iss_ptr_q - ret_ptr_q) == ADDR_WIDTH'(outst_q));
    end

    assign bus.s_ack_o   = s_ack_q;
    assign bus.s_err_o   = s_err_q;
    assign bus.s_stall_o = stall & rst_ni;
    assign bus.m_stb_o   = m_stb;
    assign bus.m_cyc_o   = m_stb | (outst_q != '0);
    assign bus.m_we_o    = 1'b1;
    assign bus.m_dat_o   = mem_q[iss_ptr_q];
    assign level_o       = level_q;
    assign almost_full_o = (level_q >= AF_L);
    assign err_o         = err_q;
endmodule

// File: tb/tb_wb_fifo_pipelined.sv
// Directed plus random stimulus against a queue-based model of the bridge.
module tb_wb_fifo_pipelined;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MAXO  = 2;
    localparam int AF    = 14;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW:0]   level_o;
    logic          almost_full_o;
    logic          err_o;

    int total = 0;
    int bad   = 0;

    // Model: words waiting to issue, words on the downstream bus
    logic [DW-1:0] mq[$];
    logic [DW-1:0] fq[$];
    logic          m_err  = 1'b0;
    logic          m_sack = 1'b0;
    logic          m_serr = 1'b0;

    wb_fifo_pipelined_if #(.DATA_WIDTH(DW)) bus();

    wb_fifo_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .AF_THRESH(AF)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave), .flush_i(flush_i),
        .level_o(level_o), .almost_full_o(almost_full_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        fq.delete();
        m_err  = 1'b0;
        m_sack = 1'b0;
        m_serr = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check, predict, advance
    task automatic step(input logic cyc, stb, we, input logic [DW-1:0] dat,
                        input logic stall, ack, err, flush);
        int   lvl;
        logic exp_stb, exp_stall, req, retire, issue;
        bus.s_cyc_i = cyc; bus.s_stb_i = stb; bus.s_we_i = we; bus.s_dat_i = dat;
        bus.m_stall_i = stall; bus.m_ack_i = ack; bus.m_err_i = err; flush_i = flush;
        #1;
        lvl       = mq.size() + fq.size();
        exp_stb   = (mq.size() > 0) && (fq.size() < MAXO);
        req       = cyc & stb;
        exp_stall = req & we & ((lvl == DEPTH) | flush);
        chk("level", level_o, lvl);
        chk("almost_full", almost_full_o, lvl >= AF);
        chk("err_o", err_o, m_err);
        chk("s_ack", bus.s_ack_o, m_sack);
        chk("s_err", bus.s_err_o, m_serr);
        chk("s_stall", bus.s_stall_o, exp_stall);
        chk("m_stb", bus.m_stb_o, exp_stb);
        chk("m_cyc", bus.m_cyc_o, exp_stb || (fq.size() > 0));
        chk("m_we", bus.m_we_o, 1'b1);
        if (exp_stb) chk("m_dat", bus.m_dat_o, mq[0]);
        m_sack = req & we & ~exp_stall;
        m_serr = req & ~we;
        retire = (ack | err) && (fq.size() > 0);
        issue  = exp_stb && !stall && !flush;
        if (retire) begin
            void'(fq.pop_front());
            if (err) m_err = 1'b1;
        end
        if (issue) fq.push_back(mq.pop_front());
        if (flush) begin
            mq.delete();
            if (!(retire && err)) m_err = 1'b0;
        end
        if (m_sack) mq.push_back(dat);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic stall, ack);
        step(1'b0, 1'b0, 1'b0, '0, stall, ack, 1'b0, 1'b0);
    endtask

    initial begin
        bus.s_cyc_i = 0; bus.s_stb_i = 0; bus.s_we_i = 0; bus.s_dat_i = '0;
        bus.m_ack_i = 0; bus.m_err_i = 0; bus.m_stall_i = 0;
        model_reset();

        // Outputs while held in reset
        @(negedge clk);
        chk("rst_level", level_o, 0);
        chk("rst_m_cyc", bus.m_cyc_o, 0);
        chk("rst_m_stb", bus.m_stb_o, 0);
        chk("rst_s_ack", bus.s_ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_m_we", bus.m_we_o, 1);
        rst_ni = 1'b1;

        // Single word, ack one cycle after issue
        step(1, 1, 1, 8'hA5, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 1);
        idle(0, 0);

        // Fill with downstream stalled; 17th push must stall
        for (int i = 0; i < 17; i++) step(1, 1, 1, DW'(i + 1), 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 8'd17, 0, 1, 0, 0);
        for (int i = 0; i < 60; i++) idle(0, (i % 3) == 2);

        // Four words with slow acks
        for (int i = 0; i < 4; i++) step(1, 1, 1, DW'(8'h40 + i), 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) idle(0, (i % 3) == 2);

        // Error on the second of three words, sticky until flush
        for (int i = 0; i < 3; i++) step(1, 1, 1, DW'(8'h60 + i), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 0, 1, i == 2, 0);
        idle(0, 0);
        idle(0, 0);
        step(0, 0, 0, '0, 0, 0, 0, 1);
        idle(0, 0);

        // Flush with 5 queued, 1 in flight; push in flush cycle is stalled
        for (int i = 0; i < 5; i++) step(1, 1, 1, DW'(8'h80 + i), 1, 0, 0, 0);
        idle(0, 0);
        step(1, 1, 1, 8'hEE, 1, 0, 0, 1);
        idle(0, 0);
        idle(0, 1);
        idle(0, 0);

        // Upstream read request
        step(1, 1, 0, '0, 0, 0, 0, 0);
        idle(0, 0);

        // Random traffic with varying pressure
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
                     $urandom_range(0, 19) != 0, DW'($urandom),
                     $urandom_range(0, 9) < 3 + 2 * p, $urandom_range(0, 9) < 6 - 2 * p,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
            end
        end

        // Reset mid-burst
        for (int i = 0; i < 4; i++) step(1, 1, 1, DW'(8'hC0 + i), 0, 0, 0, 0);
        bus.m_ack_i = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        chk("midrst_m_cyc", bus.m_cyc_o, 0);
        chk("midrst_m_stb", bus.m_stb_o, 0);
        chk("midrst_s_ack", bus.s_ack_o, 0);
        chk("midrst_level", level_o, 0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) idle(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
